// File: rtl/pattern_sweep_checker_if.sv
// pattern_sweep_checker_if: control, golden-table and status bundle between a sweep engine and its driver.
interface pattern_sweep_checker_if #(parameter int WIDTH = 4);
    logic start;
    logic abort;
    logic [1:0] mode;
    logic [2**WIDTH-1:0] expect_table;
    logic dut_out;
    logic [WIDTH-1:0] vec;
    logic busy;
    logic done;
    logic pass;
    logic [WIDTH:0] err_count;
    logic [WIDTH-1:0] first_err_vec;
    logic first_err_valid;
    modport master (
        output start, abort, mode, expect_table, dut_out,
        input vec, busy, done, pass, err_count, first_err_vec, first_err_valid
    );
    modport slave (
        input start, abort, mode, expect_table, dut_out,
        output vec, busy, done, pass, err_count, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/pattern_sweep_checker.sv
// pattern_sweep_checker: walks every WIDTH-bit vector in up/down/Gray order, holds each DWELL cycles, checks against a golden table.
module pattern_sweep_checker #(
    parameter int WIDTH = 4,
    parameter int DWELL = 100
) (
    input logic clk,
    input logic rst_n,
    pattern_sweep_checker_if.slave bus
);
    localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] idx, vec, fev;
    logic [DW-1:0] dwell_cnt;
    logic [1:0] mode_q;
    logic [WIDTH:0] err;
    logic fval, check_edge, last_vec, accept, miss;
    function automatic logic [WIDTH-1:0] map(input logic [1:0] m, input logic [WIDTH-1:0] i);
        return m == 2'd1 ? ~i : m == 2'd2 ? i ^ (i >> 1) : i;
    endfunction
    always_comb begin
        check_edge = state == RUN && dwell_cnt == DLAST;
        last_vec = idx == '1;
        accept = bus.start && !bus.abort && state != RUN;
        miss = bus.dut_out != bus.expect_table[vec];
        state_nx = bus.abort ? IDLE : accept ? RUN : (check_edge && last_vec) ? DONE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            vec <= '0;
            dwell_cnt <= '0;
            mode_q <= '0;
            err <= '0;
            fev <= '0;
            fval <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus.abort) begin
                vec <= '0;
            end else if (accept) begin
                idx <= '0;
                dwell_cnt <= '0;
                mode_q <= bus.mode;
                vec <= map(bus.mode, '0);
                err <= '0;
                fev <= '0;
                fval <= 1'b0;
            end else if (state == RUN) begin
                dwell_cnt <= check_edge ? '0 : dwell_cnt + 1'b1;
                if (check_edge) begin
                    if (miss) err <= err + 1'b1;
                    if (miss && !fval) begin
                        fev <= vec;
                        fval <= 1'b1;
                    end
                    // the final vector stays on the bus once the sweep completes
                    if (!last_vec) begin
                        idx <= idx + 1'b1;
                        vec <= map(mode_q, idx + 1'b1);
                    end
                end
            end
        end
    end
    assign bus.vec = vec;
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.pass = state == DONE && err == '0;
    assign bus.err_count = err;
    assign bus.first_err_vec = fev;
    assign bus.first_err_valid = fval;
endmodule

// File: tb/tb_pattern_sweep_checker.sv
// tb_pattern_sweep_checker: scoreboard bench driving two sweep engines (DWELL 4 and 1) against a list-based reference model.
module tb_pattern_sweep_checker;
    localparam int W = 4;
    localparam int N = 16;
    typedef struct packed {
        logic [63:0] seq;
        logic [4:0] errs;
        logic [3:0] fev;
        logic fval;
    } sb_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [N-1:0] dut_tt = '0;
    logic [N-1:0] table_r = '0;
    int sel = 0;
    int checks = 0;
    int failures = 0;
    logic [16:0] outs_w [2];
    sb_t q0[$];
    sb_t q1[$];
    always #5 clk = ~clk;
    pattern_sweep_checker_if #(.WIDTH(W)) bus [2] ();
    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask
    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gen_u
            localparam int DW = g == 0 ? 4 : 1;
            logic [3:0] s[$];
            logic pd = 1'b0;
            pattern_sweep_checker #(.WIDTH(W), .DWELL(DW)) u (.clk(clk), .rst_n(rst_n), .bus(bus[g]));
            assign bus[g].start = start && sel == g;
            assign bus[g].abort = abort && sel == g;
            assign bus[g].mode = mode;
            assign bus[g].expect_table = table_r;
            assign bus[g].dut_out = dut_tt[bus[g].vec];
            assign outs_w[g] = {bus[g].vec, bus[g].busy, bus[g].done, bus[g].pass,
                                bus[g].err_count, bus[g].first_err_vec, bus[g].first_err_valid};
            always @(negedge clk) begin
                sb_t e;
                int bad;
                if (!rst_n) begin
                    s.delete();
                    pd = 1'b0;
                end else begin
                    if (bus[g].busy) s.push_back(bus[g].vec);
                    if (bus[g].done && !pd) begin
                        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_done u%0d actual=done required=no_done", g);
                        end else begin
                            if (g == 0) e = q0.pop_front();
                            else e = q1.pop_front();
                            bad = -1;
                            for (int k = 0; k < s.size() && k < N * DW; k++)
                                if (bad < 0 && s[k] != e.seq[(k / DW) * 4 +: 4]) bad = k;
                            chk($sformatf("u%0d_busy_cycles", g), s.size(), N * DW);
                            chk($sformatf("u%0d_vec_seq_first_bad", g), bad, -1);
                            chk($sformatf("u%0d_err_count", g), int'(bus[g].err_count), int'(e.errs));
                            chk($sformatf("u%0d_first_err_vec", g), int'(bus[g].first_err_vec), int'(e.fev));
                            chk($sformatf("u%0d_first_err_valid", g), int'(bus[g].first_err_valid), int'(e.fval));
                            chk($sformatf("u%0d_pass", g), int'(bus[g].pass), int'(e.errs == 0));
                        end
                        s.delete();
                    end else if (!bus[g].busy && !bus[g].done) begin
                        s.delete();
                    end
                    pd = bus[g].done;
                end
            end
        end
    endgenerate
    // Gray order is built by reflection rather than the xor formula
    function automatic sb_t model(input int m, input logic [15:0] flip);
        int order[$];
        int n;
        sb_t e;
        e = '0;
        if (m == 2) begin
            order.push_back(0);
            for (int b = 0; b < W; b++) begin
                n = order.size();
                for (int k = n - 1; k >= 0; k--) order.push_back(order[k] | (1 << b));
            end
        end else begin
            for (int i = 0; i < N; i++) order.push_back(m == 1 ? N - 1 - i : i);
        end
        for (int i = 0; i < N; i++) begin
            e.seq[i * 4 +: 4] = 4'(order[i]);
            if (flip[order[i]]) begin
                e.errs = e.errs + 5'd1;
                if (!e.fval) begin
                    e.fev = 4'(order[i]);
                    e.fval = 1'b1;
                end
            end
        end
        return e;
    endfunction
    task automatic sweep(input int s_sel, input int m, input logic [15:0] flip);
        int n;
        sb_t e;
        n = 0;
        e = model(m, flip);
        @(negedge clk);
        dut_tt = 16'($urandom);
        table_r = dut_tt ^ flip;
        mode = 2'(m);
        sel = s_sel;
        if (s_sel == 0) q0.push_back(e);
        else q1.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!outs_w[s_sel][11] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_completes", int'(n < 2000), 1);
    endtask
    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outs_u0", int'(outs_w[0]), 0);
        chk("reset_outs_u1", int'(outs_w[1]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 0, 16'h0000);
        sweep(0, 0, 16'h0220);
        sweep(1, 2, 16'h0000);
        sweep(0, 1, 16'h4000);
        sweep(1, 1, 16'h4000);
        @(negedge clk);
        dut_tt = 16'($urandom);
        table_r = dut_tt ^ 16'h0003;
        mode = 2'd0;
        sel = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", int'(bus[0].busy), 0);
        chk("abort_done", int'(bus[0].done), 0);
        chk("abort_vec", int'(bus[0].vec), 0);
        chk("abort_err_count_held", int'(bus[0].err_count), 2);
        chk("abort_first_err_valid_held", int'(bus[0].first_err_valid), 1);
        repeat (3) @(negedge clk);
        chk("start_with_abort_ignored", int'(bus[0].busy), 0);
        sweep(0, 3, 16'h8010);
        @(negedge clk);
        dut_tt = 16'($urandom);
        table_r = dut_tt ^ 16'h0001;
        mode = 2'd0;
        sel = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("err_before_reset", int'(bus[0].err_count), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_outs", int'(outs_w[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_reset", int'(outs_w[0][12:11]), 0);
        for (int i = 0; i < 6; i++) sweep(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 16'($urandom));
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
